// File: rtl/hilo_mult_seq_if.sv
// rtl/hilo_mult_seq_if.sv - control, multiplier and HI/LO signal bundle for hilo_mult_seq
//
// Ports (signals carried by the interface):
//   start      : mult request from the main control unit
//   mthi/mtlo  : write wdata into HI / LO
//   wdata      : 32-bit data for mthi/mtlo
//   mult_hi/lo : 32-bit Hi/Lo result from the Booth multiplier
//   mult_start : one-cycle load pulse to the multiplier's local reset
//   busy       : operation in flight (pipeline stall)
//   done       : one-cycle completion pulse
//   hi_out/lo_out : architectural HI / LO registers
// Modports: master = control unit + multiplier side, slave = sequencer.
interface hilo_mult_seq_if;
    logic        start;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_start;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, mthi, mtlo, wdata, mult_hi, mult_lo,
        input  mult_start, busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, mthi, mtlo, wdata, mult_hi, mult_lo,
        output mult_start, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_mult_seq.sv
// rtl/hilo_mult_seq.sv - sequencer and HI/LO register stage around the iterative Booth multiplier
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous reset, active low
//   bus   : hilo_mult_seq_if.slave (start/mthi/mtlo/wdata/mult_hi/mult_lo in;
//           mult_start/busy/done/hi_out/lo_out out)
// Flow: IDLE -start-> LAUNCH (mult_start) -> RUN (MULT_CYCLES edges) -> CAPTURE
//       (latch mult_hi/mult_lo, pulse done) -> IDLE.
// Every output is a register or a decode of the state register; no input
// reaches an output combinationally.
module hilo_mult_seq #(
    parameter int MULT_CYCLES = 32,
    parameter int CNT_W       = 6
) (
    input  logic           clk,
    input  logic           reset,
    hilo_mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi_q, hi_nxt;
    logic [31:0]        lo_q, lo_nxt;
    logic               done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        done_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                // start has priority; a register write in the same cycle is dropped
                if (bus.start) begin
                    state_nxt = LAUNCH;
                end else begin
                    if (bus.mthi) hi_nxt = bus.wdata;
                    if (bus.mtlo) lo_nxt = bus.wdata;
                end
            end
            LAUNCH: begin
                // the multiplier loads on this edge; its MULT_CYCLES iterations follow
                cnt_nxt   = CNT_W'(MULT_CYCLES);
                state_nxt = RUN;
            end
            RUN: begin
                // cnt is always >= 1 here, so the decrement cannot wrap
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                hi_nxt    = bus.mult_hi;
                lo_nxt    = bus.mult_lo;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mult_start = (state == LAUNCH);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb/tb_hilo_mult_seq.sv - directed self-checking bench for hilo_mult_seq
module tb_hilo_mult_seq;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hilo_mult_seq_if bus ();

    hilo_mult_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-operation observations; k=0 is the first negedge after the start edge.
    int          ms_cnt, ms_first, busy_cnt, done_cnt;
    int          done_k0, done_k1;
    logic [31:0] hi_d0, lo_d0, hi_d1, lo_d1;

    task automatic observe(input int ncyc, input int inj_at, input bit restart);
        ms_cnt = 0; ms_first = -1; busy_cnt = 0; done_cnt = 0;
        done_k0 = -1; done_k1 = -1;
        hi_d0 = '0; lo_d0 = '0; hi_d1 = '0; lo_d1 = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.mult_start) begin
                if (ms_cnt == 0) ms_first = k;
                ms_cnt++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (done_cnt == 0) begin
                    done_k0 = k; hi_d0 = bus.hi_out; lo_d0 = bus.lo_out;
                end else if (done_cnt == 1) begin
                    done_k1 = k; hi_d1 = bus.hi_out; lo_d1 = bus.lo_out;
                end
                done_cnt++;
            end
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            if (k + 1 == inj_at) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'hAAAA5555;
            end
            if (restart && bus.done && done_cnt == 1) bus.start = 1'b1;
        end
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.mult_start} !== 67'd0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: hi=%h lo=%h busy=%b done=%b ms=%b required all zero",
                         i, bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.mult_start);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h12345678;
        @(negedge clk);
        bus.mtlo = 1'b0;
        checks++;
        if (bus.hi_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mthi: hi_out=%h required DEADBEEF", bus.hi_out);
        end
        checks++;
        if (bus.lo_out !== 32'h12345678) begin
            failures++; $display("FAIL mtlo: lo_out=%h required 12345678", bus.lo_out);
        end
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h5;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        checks++;
        if ({bus.hi_out, bus.lo_out} !== {32'h5, 32'h5}) begin
            failures++; $display("FAIL mthi_mtlo_same: hi=%h lo=%h required 5/5", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL mt_busy: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_mult_basic();
        // -3 * 7 = -21
        bus.mult_hi = 32'hFFFFFFFF; bus.mult_lo = 32'hFFFFFFEB;
        bus.start = 1'b1;
        observe(45, -1, 1'b0);
        checks++;
        if (ms_cnt !== 1 || ms_first !== 0) begin
            failures++; $display("FAIL basic_mult_start: count=%0d at=%0d required 1 at 0", ms_cnt, ms_first);
        end
        checks++;
        if (busy_cnt !== 34) begin
            failures++; $display("FAIL basic_busy: cycles=%0d required 34", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_k0 !== 34) begin
            failures++; $display("FAIL basic_done: count=%0d at=%0d required 1 at 34", done_cnt, done_k0);
        end
        checks++;
        if ({hi_d0, lo_d0} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
            failures++; $display("FAIL basic_product: hi=%h lo=%h required FFFFFFFF/FFFFFFEB", hi_d0, lo_d0);
        end
    endtask

    task automatic test_busy_ignore();
        // 0x10000 * 0x10000 = 0x1_0000_0000
        bus.mult_hi = 32'h00000001; bus.mult_lo = 32'h00000000;
        bus.start = 1'b1;
        observe(45, 10, 1'b0);
        checks++;
        if (ms_cnt !== 1) begin
            failures++; $display("FAIL ignore_mult_start: count=%0d required 1", ms_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_k0 !== 34) begin
            failures++; $display("FAIL ignore_done: count=%0d at=%0d required 1 at 34", done_cnt, done_k0);
        end
        checks++;
        if ({hi_d0, lo_d0} !== {32'h1, 32'h0}) begin
            failures++; $display("FAIL ignore_product: hi=%h lo=%h required 00000001/00000000", hi_d0, lo_d0);
        end
        checks++;
        if ({bus.hi_out, bus.lo_out} !== {32'h1, 32'h0}) begin
            failures++; $display("FAIL ignore_final: hi=%h lo=%h required 00000001/00000000", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.mult_hi = 32'h12121212; bus.mult_lo = 32'h34343434;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL midrun_busy_before: busy=%b required 1", bus.busy);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.mult_start, bus.hi_out, bus.lo_out} !== 67'd0) begin
            failures++; $display("FAIL midrun_reset: busy=%b done=%b ms=%b hi=%h lo=%h required all zero",
                                 bus.busy, bus.done, bus.mult_start, bus.hi_out, bus.lo_out);
        end
        observe(40, -1, 1'b0);
        checks++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            failures++; $display("FAIL midrun_no_done: done=%0d busy=%0d required 0/0", done_cnt, busy_cnt);
        end
        // 6 * 7 = 42
        bus.mult_hi = 32'h0; bus.mult_lo = 32'd42;
        bus.start = 1'b1;
        observe(40, -1, 1'b0);
        checks++;
        if (done_cnt !== 1 || done_k0 !== 34 || {hi_d0, lo_d0} !== {32'h0, 32'd42}) begin
            failures++; $display("FAIL midrun_fresh: count=%0d at=%0d hi=%h lo=%h required 1 at 34 0/0000002a",
                                 done_cnt, done_k0, hi_d0, lo_d0);
        end
    endtask

    task automatic test_back_to_back();
        bus.mult_hi = 32'h0; bus.mult_lo = 32'd42;
        bus.start = 1'b1;
        observe(80, -1, 1'b1);
        checks++;
        if (done_cnt !== 2 || done_k0 !== 34 || done_k1 !== 69) begin
            failures++; $display("FAIL b2b_done: count=%0d at=%0d,%0d required 2 at 34,69", done_cnt, done_k0, done_k1);
        end
        checks++;
        if (ms_cnt !== 2) begin
            failures++; $display("FAIL b2b_mult_start: count=%0d required 2", ms_cnt);
        end
        checks++;
        if (busy_cnt !== 68) begin
            failures++; $display("FAIL b2b_busy: cycles=%0d required 68", busy_cnt);
        end
        checks++;
        if ({hi_d1, lo_d1} !== {32'h0, 32'd42}) begin
            failures++; $display("FAIL b2b_product: hi=%h lo=%h required 0/0000002a", hi_d1, lo_d1);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.wdata = '0; bus.mult_hi = '0; bus.mult_lo = '0;
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_mult_basic();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_mult_seq.md
Name: hilo_mult_seq

Overview:
- Sequencer and HI/LO register stage wrapped around the 32-cycle Booth multiplier.
- Upstream role: accepts a mult request from the main control unit and issues the multiplier's one-cycle local-reset/load pulse. It then counts the iteration cycles.
- Downstream role: captures the multiplier's Hi/Lo result into the architectural HI/LO registers and reports completion. It also services mthi/mtlo writes and provides the HI/LO values read by mfhi/mflo.

Parameters:
- MULT_CYCLES, 32, number of multiplier iteration cycles after the load pulse.
- CNT_W, 6, counter width. Must satisfy 2^CNT_W > MULT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- start  in  1  mult request, sampled in IDLE only.
- mthi  in  1  write wdata to HI, honoured in IDLE only.
- mtlo  in  1  write wdata to LO, honoured in IDLE only.
- wdata  in  32  data for mthi/mtlo.
- mult_hi  in  32  multiplier Hi result.
- mult_lo  in  32  multiplier Lo result.
- mult_start  out  1  one-cycle load pulse to the multiplier's local reset input.
- busy  out  1  high while an operation is in flight; drives the pipeline stall.
- done  out  1  one-cycle pulse; hi_out/lo_out hold the new product in the same cycle.
- hi_out  out  32  architectural HI.
- lo_out  out  32  architectural LO.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, cnt=0, hi_out=0, lo_out=0, mult_start=0, busy=0, done=0. Reset wins over every other input.
- Reset mid-operation aborts the operation. No capture occurs and done never pulses. The next start launches a fresh operation.
- All outputs are registered or decoded from state only (Moore). No combinational path from any input to any output.
- States: IDLE, LAUNCH, RUN, CAPTURE.
- IDLE:
  - start=1 → LAUNCH.
  - else mthi=1 → hi_out<=wdata; mtlo=1 → lo_out<=wdata. Both in the same cycle write both registers.
  - start together with mthi/mtlo: start wins and the writes are dropped.
- LAUNCH: mult_start=1 for exactly this cycle. On the edge: cnt<=MULT_CYCLES, → RUN.
- RUN:
  - cnt<=cnt-1 each edge.
  - On the edge where cnt==1 (cnt becomes 0) → CAPTURE.
  - Exactly MULT_CYCLES RUN edges, matching the multiplier's iteration count after its load edge.
- CAPTURE:
  - mult_hi/mult_lo are valid.
  - On the edge: hi_out<=mult_hi, lo_out<=mult_lo, done<=1, → IDLE.
- done is high only in the single cycle after CAPTURE; it is cleared on the next edge.
- busy=1 in LAUNCH, RUN and CAPTURE; 0 in IDLE, including the done cycle.
- Latency: start sampled at edge E0 → new hi_out/lo_out and done=1 after edge E0+MULT_CYCLES+2 (34 by default).
- Back-to-back: start may be high in the done cycle; it is accepted (state is IDLE).
- Ignored while busy: start, mthi and mtlo are ignored with no queuing. hi_out/lo_out keep their previous values until capture.
- mult_hi/mult_lo are ignored in every state except CAPTURE.
- cnt never wraps: it is only decremented in RUN, where cnt≥1.

Test Plan:
- Reset then idle 5 cycles → hi_out=0, lo_out=0, busy=0, done=0, mult_start=0 throughout.
- mthi with wdata=32'hDEADBEEF, next cycle mtlo with wdata=32'h12345678 → hi_out=DEADBEEF, lo_out=12345678. Same-cycle mthi+mtlo with wdata=32'h5 → both equal 5.
- start with the real multiplier attached (A=-3, B=7) → mult_start high exactly 1 cycle, one cycle after start. busy high for 34 cycles. done pulses at E0+34 with hi_out=32'hFFFFFFFF, lo_out=32'hFFFFFFEB.
- start, then at cycle 10 assert start, mthi=1, wdata=32'hAAAA5555 → both ignored. A single mult_start pulse. Final hi_out/lo_out equal the product, not AAAA5555.
- reset asserted at RUN cycle 15 → next cycle state IDLE, busy=0, hi_out=lo_out=0, no done pulse. A following start (A=6, B=7) completes with lo_out=42, hi_out=0.
- start held high in the done cycle → a second operation launches immediately. Two done pulses exactly 35 cycles apart.
